// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg
//   Shared constants and helpers for the BCD counter / 7-segment display.
//   Segment patterns are active-high, bit order {g,f,e,d,c,b,a}; output
//   polarity is applied later, at the display output register.
//   Contents:
//     SEG_0..SEG_9, SEG_BLANK  segment patterns
//     seg_decode(nibble)       0-9 -> pattern, anything else -> SEG_BLANK
//     bcd_clean(nibble)        nibbles above 9 are forced to 0
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    function automatic logic [3:0] bcd_clean(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd0 : nibble;
    endfunction

endpackage

// File: rtl/bcd_updown_scan_display_digit_step.sv
// ---------------------------------------------------------------------------
// bcd_digit_step
//   One BCD digit of the up/down counter. Purely combinational so that a
//   chain of these ripples carry/borrow across all digits in one cycle.
//   Ports:
//     d       in  4  current digit value (always 0..9)
//     up      in  1  1 = increment, 0 = decrement
//     cin     in  1  carry (up) / borrow (down) request from the lower digit
//     d_next  out 4  digit value after the step
//     cout    out 1  carry/borrow into the next higher digit
// ---------------------------------------------------------------------------
module bcd_digit_step (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] d_next,
    output logic       cout
);

    always_comb begin
        d_next = d;
        cout   = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    d_next = 4'd0;
                    cout   = 1'b1;
                end else begin
                    d_next = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    d_next = 4'd9;
                    cout   = 1'b1;
                end else begin
                    d_next = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_updown_scan_display
//   NUM_DIGITS-digit BCD up/down counter stepped by a prescaler, with
//   synchronous load, full-range wrap pulse and a time-multiplexed 7-segment
//   driver (optional leading-zero blanking, selectable output polarity).
//   Ports:
//     clk        in   1             system clock
//     rst_n      in   1             asynchronous active-low reset
//     en         in   1             count enable (prescaler runs only while set)
//     up_dn      in   1             1 = count up, 0 = count down
//     load       in   1             synchronous load strobe (beats a step)
//     load_val   in   4*NUM_DIGITS  BCD load value, digit 0 in [3:0]
//     count_bcd  out  4*NUM_DIGITS  registered count, digit 0 in [3:0]
//     wrap       out  1             one-cycle pulse on full-range wrap
//     seg        out  7             segments {g,f,e,d,c,b,a}
//     an         out  NUM_DIGITS    one-hot digit enable
// ---------------------------------------------------------------------------
module bcd_updown_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int TICK_DIV      = 12_500_000,
    parameter int SCAN_DIV_W    = 18,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]         presc_reg;
    logic [CW-1:0]         count_reg;
    logic                  wrap_reg;
    logic [SCAN_DIV_W-1:0] scan_reg;
    logic [IW-1:0]         idx_reg;
    logic [6:0]            seg_reg;
    logic [NUM_DIGITS-1:0] an_reg;

    logic                  step;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         load_clean;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS:0]   upper_zero;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    // With TICK_DIV=1 PRESC_LAST is 0 and the prescaler never leaves 0,
    // so every enabled cycle is a step.
    assign step = en && (presc_reg == PRESC_LAST);

    // Digit 0 always receives the step request; the chain decides how far
    // the carry/borrow travels. The final carry out is the full-range wrap.
    assign carry[0] = 1'b1;

    // upper_zero[k]: digits k..NUM_DIGITS-1 are all zero (used for blanking).
    assign upper_zero[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit_step u_step (
            .d      (count_reg[4*gi +: 4]),
            .up     (up_dn),
            .cin    (carry[gi]),
            .d_next (count_next[4*gi +: 4]),
            .cout   (carry[gi+1])
        );

        assign load_clean[4*gi +: 4] = bcd_clean(load_val[4*gi +: 4]);
        assign upper_zero[gi]        = upper_zero[gi+1] && (count_reg[4*gi +: 4] == 4'd0);
    end

    // Prescaler, count and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else if (load) begin
            // A step coinciding with a load is dropped, not deferred.
            presc_reg <= '0;
            count_reg <= load_clean;
            wrap_reg  <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (en) begin
                presc_reg <= step ? '0 : presc_reg + PW'(1);
            end
            if (step) begin
                count_reg <= count_next;
                wrap_reg  <= carry[NUM_DIGITS];
            end
        end
    end

    // Scan divider free-runs regardless of en; the digit index advances on
    // its all-ones cycle and wraps at NUM_DIGITS-1 so there is no dead slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_reg <= '0;
            idx_reg  <= '0;
        end else begin
            scan_reg <= scan_reg + SCAN_DIV_W'(1);
            if (&scan_reg) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end
        end
    end

    // Select the digit under the scan index, decide blanking, decode.
    always_comb begin
        logic [3:0] sel_nib;
        logic       sel_blank;
        sel_nib   = 4'd0;
        sel_blank = 1'b0;
        an_next   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
                sel_nib    = count_reg[4*i +: 4];
                sel_blank  = BLANK_LEADING && (i > 0) && upper_zero[i];
                an_next[i] = 1'b1;
            end
        end
        seg_next = sel_blank ? SEG_BLANK : seg_decode(sel_nib);
    end

    // Display output register; polarity is applied here only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next ^ SEG_OFF;
            an_reg  <= an_next ^ AN_OFF;
        end
    end

    assign count_bcd = count_reg;
    assign wrap      = wrap_reg;
    assign seg       = seg_reg;
    assign an        = an_reg;

endmodule

// File: tb/tb_bcd_updown_scan_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_scan_display
//   Three differently parameterised instances share one stimulus stream:
//     0: 3 digits, step every enabled cycle, 4-clk slots, active-low, blanking
//     1: 3 digits, step every 4 enabled cycles, 4-clk slots, active-low, no blanking
//     2: 4 digits, step every 3 enabled cycles, 2-clk slots, active-high, blanking
//   Each instance has an arithmetic reference model (count as an integer
//   modulo 10**N, scan index derived from cycles since reset). One process
//   compares all instances every cycle; directed tests pin literal values.
// ---------------------------------------------------------------------------
module tb_bcd_updown_scan_display;

    function automatic int p_nd(int i); return (i == 2) ? 4 : 3; endfunction
    function automatic int p_td(int i); return (i == 0) ? 1 : ((i == 1) ? 4 : 3); endfunction
    function automatic int p_sw(int i); return (i == 2) ? 1 : 2; endfunction
    function automatic bit p_al(int i); return (i != 2); endfunction
    function automatic bit p_bl(int i); return (i != 1); endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [31:0] load_val = '0;
    logic        chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] act_count [3];
    logic        act_wrap  [3];
    logic [6:0]  act_seg   [3];
    logic [7:0]  act_an    [3];
    logic [31:0] exp_count [3];
    logic        exp_wrap  [3];
    logic [6:0]  exp_seg   [3];
    logic [7:0]  exp_an    [3];

    always #5 clk = ~clk;

    // Active-high {g..a} glyphs for 0..9, written out independently.
    function automatic logic [6:0] glyph(int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic int pow10(int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(int v, int nd);
        logic [31:0] r = '0;
        for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic int bcd_value(logic [31:0] lv, int nd);
        int r = 0;
        for (int k = 0; k < nd; k++) begin
            int nib = int'(lv[4*k +: 4]);
            if (nib > 9) nib = 0;
            r = r + nib * pow10(k);
        end
        return r;
    endfunction

    function automatic logic [6:0] model_seg(int v, int idx, bit bl, bit al);
        logic [6:0] s;
        if (bl && idx > 0 && (v / pow10(idx)) == 0) s = 7'h00;
        else s = glyph((v / pow10(idx)) % 10);
        return al ? ~s : s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int ND  = p_nd(gi);
        localparam int TD  = p_td(gi);
        localparam int SW  = p_sw(gi);
        localparam bit AL  = p_al(gi);
        localparam bit BL  = p_bl(gi);
        localparam int MOD = 10 ** ND;
        localparam logic [7:0] AN_MASK = 8'((1 << ND) - 1);

        logic [4*ND-1:0] cnt;
        logic            wr;
        logic [6:0]      sg;
        logic [ND-1:0]   an_w;

        bcd_updown_scan_display #(
            .NUM_DIGITS    (ND),
            .TICK_DIV      (TD),
            .SCAN_DIV_W    (SW),
            .ACTIVE_LOW    (AL),
            .BLANK_LEADING (BL)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .up_dn     (up_dn),
            .load      (load),
            .load_val  (load_val[4*ND-1:0]),
            .count_bcd (cnt),
            .wrap      (wr),
            .seg       (sg),
            .an        (an_w)
        );

        assign act_count[gi] = 32'(cnt);
        assign act_wrap[gi]  = wr;
        assign act_seg[gi]   = sg;
        assign act_an[gi]    = 8'(an_w);

        // Reference model state.
        int         m_val  = 0;
        int         m_en   = 0;   // enabled cycles since reset/load, mod TD
        longint     m_cyc  = 0;   // clock edges since reset
        logic       m_wrap = 1'b0;
        logic [6:0] m_seg  = AL ? 7'h7F : 7'h00;
        logic [7:0] m_an   = AL ? AN_MASK : 8'h00;

        always @(posedge clk or negedge rst_n) begin : model
            int idx;
            if (!rst_n) begin
                m_val  <= 0;
                m_en   <= 0;
                m_cyc  <= 0;
                m_wrap <= 1'b0;
                m_seg  <= AL ? 7'h7F : 7'h00;
                m_an   <= AL ? AN_MASK : 8'h00;
            end else begin
                idx    = int'((m_cyc / (64'd1 << SW)) % ND);
                m_seg  <= model_seg(m_val, idx, BL, AL);
                m_an   <= 8'(1 << idx) ^ (AL ? AN_MASK : 8'h00);
                m_cyc  <= m_cyc + 1;
                if (load) begin
                    m_val  <= bcd_value(load_val, ND);
                    m_en   <= 0;
                    m_wrap <= 1'b0;
                end else if (en && m_en == TD - 1) begin
                    m_en <= 0;
                    if (up_dn) begin
                        m_val  <= (m_val + 1) % MOD;
                        m_wrap <= (m_val == MOD - 1);
                    end else begin
                        m_val  <= (m_val + MOD - 1) % MOD;
                        m_wrap <= (m_val == 0);
                    end
                end else begin
                    if (en) m_en <= m_en + 1;
                    m_wrap <= 1'b0;
                end
            end
        end

        assign exp_count[gi] = to_bcd(m_val, ND);
        assign exp_wrap[gi]  = m_wrap;
        assign exp_seg[gi]   = m_seg;
        assign exp_an[gi]    = m_an;
    end

    // Every-cycle comparison of all instances against their models.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model%0d_count", i), act_count[i], exp_count[i]);
                chk($sformatf("model%0d_wrap", i), 32'(act_wrap[i]), 32'(exp_wrap[i]));
                chk($sformatf("model%0d_seg", i), 32'(act_seg[i]), 32'(exp_seg[i]));
                chk($sformatf("model%0d_an", i), 32'(act_an[i]), 32'(exp_an[i]));
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic do_load(input logic [31:0] v);
        load     = 1'b1;
        load_val = v;
        step_cyc();
        load     = 1'b0;
    endtask

    initial begin
        logic [5:0] en_pat;

        // Reset state while rst_n is held low.
        repeat (2) step_cyc();
        chk("reset_count", act_count[0], 32'h0);
        chk("reset_wrap", 32'(act_wrap[0]), 32'h0);
        chk("reset_seg_al", 32'(act_seg[0]), 32'h7F);
        chk("reset_an_al", 32'(act_an[0]), 32'h7);
        chk("reset_seg_ah", 32'(act_seg[2]), 32'h00);
        chk("reset_an_ah", 32'(act_an[2]), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Up through full-range wrap (instance 0, step every cycle).
        en = 1'b1; up_dn = 1'b1;
        do_load(32'h998);
        chk("up_load", act_count[0], 32'h998);
        step_cyc();
        chk("up_999", act_count[0], 32'h999);
        chk("up_999_wrap", 32'(act_wrap[0]), 32'h0);
        step_cyc();
        chk("up_000", act_count[0], 32'h000);
        chk("up_000_wrap", 32'(act_wrap[0]), 32'h1);
        step_cyc();
        chk("up_001", act_count[0], 32'h001);
        chk("up_001_wrap", 32'(act_wrap[0]), 32'h0);

        // Down from zero.
        up_dn = 1'b0;
        do_load(32'h000);
        step_cyc();
        chk("dn_999", act_count[0], 32'h999);
        chk("dn_999_wrap", 32'(act_wrap[0]), 32'h1);
        step_cyc();
        chk("dn_998", act_count[0], 32'h998);
        chk("dn_998_wrap", 32'(act_wrap[0]), 32'h0);

        // Load beats a step in the same cycle; A nibble is stored as 0.
        up_dn = 1'b1;
        do_load(32'h5A7);
        chk("load_vs_step", act_count[0], 32'h507);
        chk("load_vs_step_wrap", 32'(act_wrap[0]), 32'h0);

        // Prescaler of 4 with enable pattern 1,1,0,0,1,1 (instance 1).
        en = 1'b0;
        do_load(32'h000);
        en_pat = 6'b110011;
        for (int k = 0; k < 6; k++) begin
            en = en_pat[k];
            step_cyc();
            chk($sformatf("presc_k%0d", k), act_count[1], (k == 5) ? 32'h1 : 32'h0);
        end
        en = 1'b0;

        // Scan and blanking with count 007.
        do_load(32'h007);
        for (int k = 0; k < 16; k++) begin
            step_cyc();
            case (act_an[0][2:0])
                3'b110:        chk("scan_d0_seg", 32'(act_seg[0]), 32'h78);
                3'b101, 3'b011: chk("scan_blank_seg", 32'(act_seg[0]), 32'h7F);
                default:       chk("scan_an_onehot", 32'(act_an[0]), 32'h6);
            endcase
            if (act_an[1][2:0] == 3'b011)
                chk("noblank_d2_seg", 32'(act_seg[1]), 32'h40);
        end

        // Asynchronous reset mid-count, mid-slot.
        en = 1'b1;
        do_load(32'h123);
        repeat (5) step_cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_count", act_count[0], 32'h0);
        chk("arst_wrap", 32'(act_wrap[0]), 32'h0);
        chk("arst_seg", 32'(act_seg[0]), 32'h7F);
        chk("arst_an", 32'(act_an[0]), 32'h7);
        chk("arst_count_ah", act_count[2], 32'h0);
        chk("arst_an_ah", 32'(act_an[2]), 32'h0);
        step_cyc();
        rst_n = 1'b1;

        // Randomised traffic against the models.
        for (int c = 0; c < 4000; c++) begin
            en       = ($urandom_range(0, 9) < 7);
            up_dn    = ($urandom_range(0, 3) != 0) ? up_dn : ~up_dn;
            load     = ($urandom_range(0, 39) == 0);
            load_val = $urandom;
            if ($urandom_range(0, 15) == 0) load_val = 32'h9999;
            if (c % 700 == 350) begin
                rst_n = 1'b0;
                #1;
                step_cyc();
                rst_n = 1'b1;
            end else begin
                step_cyc();
            end
        end
        load = 1'b0;
        step_cyc();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
